// File: rtl/lane_dly_pkg.sv
// Shared encodings for the lane delay-line sequencer: request opcodes,
// delay-line selectors and FSM state type.
package lane_dly_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic SEL_RX = 1'b0;
    localparam logic SEL_TX = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PULSE,
        ST_GAP,
        ST_POST,
        ST_FIN
    } state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lane_dly_timer.sv
// Loadable down-counter with zero flag; one instance times the PRE, GAP and
// POST phases of the delay-line sequencer.
module lane_dly_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pf_lanectrl_dly_seq.sv
// Sequences LOAD/MOVE pulses onto one lane's delay line, bracketed by
// HS_IO_CLK_PAUSE, and tracks the RX/TX tap positions.
module pf_lanectrl_dly_seq
    import lane_dly_pkg::*;
#(
    parameter int unsigned PAUSE_PRE  = 4,
    parameter int unsigned PAUSE_POST = 4,
    parameter int unsigned MOVE_GAP   = 2,
    parameter int unsigned TAP_W      = 8,
    parameter int unsigned LOAD_VAL   = 1
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic             REQ_SEL,
    input  logic [TAP_W-1:0] REQ_TAPS,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] TAPS_DONE,
    output logic [TAP_W-1:0] RX_TAP_POS,
    output logic [TAP_W-1:0] TX_TAP_POS,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned TMAX = max3(PAUSE_PRE, PAUSE_POST, MOVE_GAP);
    localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
    localparam logic [TAP_W-1:0] LOAD_POS = TAP_W'(LOAD_VAL);

    state_t           state;
    logic [1:0]       op_q;
    logic [TAP_W-1:0] remaining;
    logic             err_flag;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;
    logic [TAP_W-1:0] cur_pos;
    logic [TAP_W-1:0] next_pos;
    logic             oor_sel;

    // Timer is reloaded on every phase entry; a reload that turns out unused
    // (PRE/GAP exiting into PULSE) is harmless since PULSE reloads it anyway.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE:  begin tmr_load = REQ_VALID; tmr_val = TW'(PAUSE_PRE - 1);  end
            ST_PRE:   begin tmr_load = tmr_zero;  tmr_val = TW'(PAUSE_POST - 1); end
            ST_PULSE: begin tmr_load = 1'b1;      tmr_val = TW'(MOVE_GAP - 1);   end
            ST_GAP:   begin tmr_load = tmr_zero;  tmr_val = TW'(PAUSE_POST - 1); end
            default:  ;
        endcase
    end

    lane_dly_timer #(.W(TW)) u_timer (
        .clk      (FAB_CLK),
        .rst      (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        cur_pos = (DELAY_LINE_SEL == SEL_TX) ? TX_TAP_POS : RX_TAP_POS;
        oor_sel = (DELAY_LINE_SEL == SEL_TX) ? TX_DELAY_LINE_OUT_OF_RANGE
                                             : RX_DELAY_LINE_OUT_OF_RANGE;
        case (op_q)
            OP_LOAD: next_pos = LOAD_POS;
            OP_INC:  next_pos = (cur_pos == '1) ? cur_pos : cur_pos + 1'b1;
            OP_DEC:  next_pos = (cur_pos == '0) ? cur_pos : cur_pos - 1'b1;
            default: next_pos = cur_pos;
        endcase
    end

    assign REQ_READY = (state == ST_IDLE) && !RESET;

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state                <= ST_IDLE;
            op_q                 <= OP_LOAD;
            remaining            <= '0;
            err_flag             <= 1'b0;
            DONE                 <= 1'b0;
            ERR                  <= 1'b0;
            TAPS_DONE            <= '0;
            RX_TAP_POS           <= LOAD_POS;
            TX_TAP_POS           <= LOAD_POS;
            DELAY_LINE_SEL       <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            HS_IO_CLK_PAUSE      <= 1'b0;
        end else begin
            DELAY_LINE_LOAD <= 1'b0;
            DELAY_LINE_MOVE <= 1'b0;
            DONE            <= 1'b0;
            ERR             <= 1'b0;
            case (state)
                ST_IDLE: if (REQ_VALID) begin
                    op_q                 <= REQ_OP;
                    DELAY_LINE_SEL       <= REQ_SEL;
                    DELAY_LINE_DIRECTION <= (REQ_OP == OP_INC);
                    remaining            <= (REQ_OP == OP_LOAD) ? TAP_W'(1) :
                                            (REQ_OP == OP_RSVD) ? '0 : REQ_TAPS;
                    err_flag             <= (REQ_OP == OP_RSVD);
                    TAPS_DONE            <= '0;
                    HS_IO_CLK_PAUSE      <= 1'b1;
                    state                <= ST_PRE;
                end
                ST_PRE: if (tmr_zero) begin
                    if (remaining != '0) begin
                        DELAY_LINE_LOAD <= (op_q == OP_LOAD);
                        DELAY_LINE_MOVE <= (op_q != OP_LOAD);
                        state           <= ST_PULSE;
                    end else begin
                        state <= ST_POST;
                    end
                end
                ST_PULSE: begin
                    remaining <= remaining - 1'b1;
                    if (DELAY_LINE_SEL == SEL_TX) TX_TAP_POS <= next_pos;
                    else                          RX_TAP_POS <= next_pos;
                    if (op_q != OP_LOAD) TAPS_DONE <= TAPS_DONE + 1'b1;
                    state <= ST_GAP;
                end
                ST_GAP: if (tmr_zero) begin
                    if (oor_sel) begin
                        err_flag <= 1'b1;
                        state    <= ST_POST;
                    end else if (remaining != '0) begin
                        DELAY_LINE_LOAD <= (op_q == OP_LOAD);
                        DELAY_LINE_MOVE <= (op_q != OP_LOAD);
                        state           <= ST_PULSE;
                    end else begin
                        state <= ST_POST;
                    end
                end
                ST_POST: if (tmr_zero) begin
                    HS_IO_CLK_PAUSE <= 1'b0;
                    DONE            <= 1'b1;
                    ERR             <= err_flag;
                    state           <= ST_FIN;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pf_lanectrl_dly_seq.sv
// Directed bench for pf_lanectrl_dly_seq: per-request traces of pulses,
// pause and completion, checked against hand-computed cycle offsets.
module tb_pf_lanectrl_dly_seq;

    logic       FAB_CLK;
    logic       RESET;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic       REQ_SEL;
    logic [7:0] REQ_TAPS;
    logic       DONE;
    logic       ERR;
    logic [7:0] TAPS_DONE;
    logic [7:0] RX_TAP_POS;
    logic [7:0] TX_TAP_POS;
    logic       DELAY_LINE_SEL;
    logic       DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_LOAD;
    logic       DELAY_LINE_MOVE;
    logic       HS_IO_CLK_PAUSE;
    logic       RX_DELAY_LINE_OUT_OF_RANGE;
    logic       TX_DELAY_LINE_OUT_OF_RANGE;

    pf_lanectrl_dly_seq #(
        .PAUSE_PRE  (4),
        .PAUSE_POST (4),
        .MOVE_GAP   (2),
        .TAP_W      (8),
        .LOAD_VAL   (1)
    ) dut (
        .FAB_CLK                    (FAB_CLK),
        .RESET                      (RESET),
        .REQ_VALID                  (REQ_VALID),
        .REQ_READY                  (REQ_READY),
        .REQ_OP                     (REQ_OP),
        .REQ_SEL                    (REQ_SEL),
        .REQ_TAPS                   (REQ_TAPS),
        .DONE                       (DONE),
        .ERR                        (ERR),
        .TAPS_DONE                  (TAPS_DONE),
        .RX_TAP_POS                 (RX_TAP_POS),
        .TX_TAP_POS                 (TX_TAP_POS),
        .DELAY_LINE_SEL             (DELAY_LINE_SEL),
        .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
        .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
        .RX_DELAY_LINE_OUT_OF_RANGE (RX_DELAY_LINE_OUT_OF_RANGE),
        .TX_DELAY_LINE_OUT_OF_RANGE (TX_DELAY_LINE_OUT_OF_RANGE)
    );

    initial begin
        FAB_CLK = 1'b0;
        forever #5 FAB_CLK = ~FAB_CLK;
    end

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [63:0] move_mask, load_mask, pause_mask;
    int          done_at;
    logic        err_d;
    logic [7:0]  tdone_d;
    logic        dir_1, sel_1;

    task automatic step();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request in the current (idle) cycle, then trace up to DONE.
    // Bit r of each mask is the output seen r cycles after the accept cycle.
    task automatic run_op(input logic [1:0] op, input logic sel, input logic [7:0] taps,
                          input int oor_at, input bit hold);
        bit fin;
        move_mask  = '0;
        load_mask  = '0;
        pause_mask = '0;
        done_at    = -1;
        err_d      = 1'bx;
        tdone_d    = 'x;
        fin        = 1'b0;
        REQ_OP     = op;
        REQ_SEL    = sel;
        REQ_TAPS   = taps;
        REQ_VALID  = 1'b1;
        for (int r = 1; r < 64 && !fin; r++) begin
            step();
            REQ_VALID = hold;
            RX_DELAY_LINE_OUT_OF_RANGE = (oor_at == r) && !sel;
            TX_DELAY_LINE_OUT_OF_RANGE = (oor_at == r) && sel;
            if (r == 1) begin
                dir_1 = DELAY_LINE_DIRECTION;
                sel_1 = DELAY_LINE_SEL;
            end
            if (DELAY_LINE_MOVE)  move_mask[r]  = 1'b1;
            if (DELAY_LINE_LOAD)  load_mask[r]  = 1'b1;
            if (HS_IO_CLK_PAUSE)  pause_mask[r] = 1'b1;
            if (DONE) begin
                done_at = r;
                err_d   = ERR;
                tdone_d = TAPS_DONE;
                fin     = 1'b1;
            end
        end
        RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
    endtask

    initial begin
        int   cnt;
        bit   seen;
        RESET = 1'b1;
        REQ_VALID = 1'b0;
        REQ_OP = 2'b00;
        REQ_SEL = 1'b0;
        REQ_TAPS = '0;
        RX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        TX_DELAY_LINE_OUT_OF_RANGE = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_ready", 64'(REQ_READY), 64'd0);
        chk("rst_pause", 64'(HS_IO_CLK_PAUSE), 64'd0);
        chk("rst_pulses", 64'({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DONE, ERR}), 64'd0);
        chk("rst_seldir", 64'({DELAY_LINE_SEL, DELAY_LINE_DIRECTION}), 64'd0);
        chk("rst_tapsdone", 64'(TAPS_DONE), 64'd0);
        chk("rst_rxpos", 64'(RX_TAP_POS), 64'd1);
        chk("rst_txpos", 64'(TX_TAP_POS), 64'd1);
        RESET = 1'b0;
        step();
        chk("rst_ready_after", 64'(REQ_READY), 64'd1);
        step();

        // 1: MOVE_INC RX x3
        run_op(2'b01, 1'b0, 8'd3, -1, 1'b0);
        chk("t1_move", move_mask, 64'h920);
        chk("t1_load", load_mask, 64'h0);
        chk("t1_pause", pause_mask, 64'h3FFFE);
        chk("t1_done", 64'(done_at), 64'd18);
        chk("t1_err", 64'(err_d), 64'd0);
        chk("t1_tdone", 64'(tdone_d), 64'd3);
        chk("t1_dirsel", 64'({dir_1, sel_1}), 64'b10);
        chk("t1_rxpos", 64'(RX_TAP_POS), 64'd4);
        step();
        chk("t1_ready_idle", 64'(REQ_READY), 64'd1);
        chk("t1_dir_held", 64'(DELAY_LINE_DIRECTION), 64'd1);

        // 2: bring TX to 9, then LOAD TX
        run_op(2'b01, 1'b1, 8'd8, -1, 1'b0);
        chk("t2_prep_done", 64'(done_at), 64'd33);
        chk("t2_prep_txpos", 64'(TX_TAP_POS), 64'd9);
        step();
        run_op(2'b00, 1'b1, 8'd7, -1, 1'b0);
        chk("t2_load", load_mask, 64'h20);
        chk("t2_move", move_mask, 64'h0);
        chk("t2_done", 64'(done_at), 64'd12);
        chk("t2_err", 64'(err_d), 64'd0);
        chk("t2_txpos", 64'(TX_TAP_POS), 64'd1);
        chk("t2_rxpos", 64'(RX_TAP_POS), 64'd4);
        step();

        // 3: MOVE_DEC RX x5 aborted by out-of-range in the first gap
        run_op(2'b10, 1'b0, 8'd5, 7, 1'b0);
        chk("t3_move", move_mask, 64'h20);
        chk("t3_done", 64'(done_at), 64'd12);
        chk("t3_err", 64'(err_d), 64'd1);
        chk("t3_tdone", 64'(tdone_d), 64'd1);
        chk("t3_rxpos", 64'(RX_TAP_POS), 64'd3);
        step();

        // 4: LOAD RX to 1, MOVE_DEC x3 saturates at 0, then a 0-tap move
        run_op(2'b00, 1'b0, 8'd0, -1, 1'b0);
        chk("t4_load_rxpos", 64'(RX_TAP_POS), 64'd1);
        step();
        run_op(2'b10, 1'b0, 8'd3, -1, 1'b0);
        chk("t4_move", move_mask, 64'h920);
        chk("t4_done", 64'(done_at), 64'd18);
        chk("t4_err", 64'(err_d), 64'd0);
        chk("t4_tdone", 64'(tdone_d), 64'd3);
        chk("t4_rxpos", 64'(RX_TAP_POS), 64'd0);
        step();
        run_op(2'b01, 1'b0, 8'd0, -1, 1'b0);
        chk("t4z_pulses", move_mask | load_mask, 64'h0);
        chk("t4z_pause", pause_mask, 64'h1FE);
        chk("t4z_done", 64'(done_at), 64'd9);
        chk("t4z_tdone", 64'(tdone_d), 64'd0);
        step();

        // 6: REQ_VALID held: next accept exactly one cycle after DONE
        run_op(2'b01, 1'b1, 8'd1, -1, 1'b1);
        chk("t6_done1", 64'(done_at), 64'd12);
        chk("t6_txpos1", 64'(TX_TAP_POS), 64'd2);
        step();
        chk("t6_ready_after_done", 64'(REQ_READY), 64'd1);
        step();
        chk("t6_accepted", 64'({REQ_READY, HS_IO_CLK_PAUSE}), 64'b01);
        REQ_VALID = 1'b0;
        cnt = 1;
        seen = 1'b0;
        while (!seen && cnt < 64) begin
            step();
            cnt++;
            seen = DONE;
        end
        chk("t6_done2", 64'(cnt), 64'd12);
        chk("t6_txpos2", 64'(TX_TAP_POS), 64'd3);
        step();
        run_op(2'b11, 1'b0, 8'd4, -1, 1'b0);
        chk("t6r_pulses", move_mask | load_mask, 64'h0);
        chk("t6r_done", 64'(done_at), 64'd9);
        chk("t6r_err", 64'(err_d), 64'd1);
        step();

        // 5: RESET mid-move (TX 3 -> 4 on first pulse, then reset)
        REQ_OP = 2'b01;
        REQ_SEL = 1'b1;
        REQ_TAPS = 8'd3;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        for (int r = 2; r <= 6; r++) step();
        chk("t5_txpos_moved", 64'(TX_TAP_POS), 64'd4);
        RESET = 1'b1;
        step();
        chk("t5_pause", 64'(HS_IO_CLK_PAUSE), 64'd0);
        chk("t5_move", 64'(DELAY_LINE_MOVE), 64'd0);
        chk("t5_done", 64'(DONE), 64'd0);
        chk("t5_ready_in_rst", 64'(REQ_READY), 64'd0);
        chk("t5_txpos", 64'(TX_TAP_POS), 64'd1);
        chk("t5_rxpos", 64'(RX_TAP_POS), 64'd1);
        RESET = 1'b0;
        step();
        chk("t5_ready", 64'(REQ_READY), 64'd1);
        seen = 1'b0;
        for (int r = 0; r < 20; r++) begin
            if (DONE || HS_IO_CLK_PAUSE) seen = 1'b1;
            step();
        end
        chk("t5_no_done", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
